// File: rtl/hgcal_quant_pkg.sv
// Shared constants, FSM state type and a reference 2-bit quantiser
// for the HGCAL input frame quantiser.
package hgcal_quant_pkg;

  localparam int Q_W      = 2;
  localparam int DEF_THR0 = 64;
  localparam int DEF_THR1 = 256;
  localparam int DEF_THR2 = 512;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Code is the number of default thresholds the sample reaches.
  function automatic logic [1:0] quant2(input int unsigned sample);
    logic [1:0] code;
    code = 2'd0;
    if (sample >= DEF_THR0) code = code + 2'd1;
    if (sample >= DEF_THR1) code = code + 2'd1;
    if (sample >= DEF_THR2) code = code + 2'd1;
    return code;
  endfunction

endpackage

// File: rtl/hgcal_sample_quantizer.sv
// Combinational 3-threshold quantiser: one unsigned sample to a 2-bit code.
module hgcal_sample_quantizer #(
  parameter int          IN_W = 10,
  parameter int unsigned THR0 = 64,
  parameter int unsigned THR1 = 256,
  parameter int unsigned THR2 = 512
) (
  input  logic [IN_W-1:0] sample_i,
  output logic [1:0]      code_o
);

  // Compare at 32 bits so thresholds above the sample range simply never hit.
  logic [31:0] sample_ext;
  logic        ge0, ge1, ge2;

  assign sample_ext = 32'(sample_i);
  assign ge0        = (sample_ext >= THR0);
  assign ge1        = (sample_ext >= THR1);
  assign ge2        = (sample_ext >= THR2);
  assign code_o     = {1'b0, ge0} + {1'b0, ge1} + {1'b0, ge2};

endmodule

// File: rtl/hgcal_input_frame_quantizer.sv
// Quantises a stream of per-channel samples and packs one frame per handshake.
// Optional saturating count of full-scale samples: define HGCAL_QUANT_SAT_CNT_EN.
module hgcal_input_frame_quantizer #(
  parameter int          N_CH = 48,
  parameter int          IN_W = 10,
  parameter int          Q_W  = hgcal_quant_pkg::Q_W,
  parameter int unsigned THR0 = hgcal_quant_pkg::DEF_THR0,
  parameter int unsigned THR1 = hgcal_quant_pkg::DEF_THR1,
  parameter int unsigned THR2 = hgcal_quant_pkg::DEF_THR2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_CH*Q_W-1:0] out_data,
`ifdef HGCAL_QUANT_SAT_CNT_EN
  output logic [15:0]         sat_count,
`endif
  output logic                frame_err
);

  import hgcal_quant_pkg::*;

  if (Q_W != 2) begin : g_bad_q_w
    $error("hgcal_input_frame_quantizer: Q_W must be 2");
  end
  if (!(THR0 < THR1 && THR1 < THR2)) begin : g_bad_thr
    $error("hgcal_input_frame_quantizer: thresholds must be strictly increasing");
  end

  localparam int                CNT_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int                OUT_W   = N_CH * Q_W;
  localparam logic [CNT_W-1:0]  LAST_CH = CNT_W'(N_CH - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   ch_cnt_q;
  logic [OUT_W-1:0]   shadow_q, shadow_d;
  logic [OUT_W-1:0]   out_data_q;
  logic               out_valid_q;
  logic               frame_err_q;
  logic [Q_W-1:0]     code;
  logic               beat_acc, at_last_ch, good_last, bad_frame;

  hgcal_sample_quantizer #(
    .IN_W (IN_W),
    .THR0 (THR0),
    .THR1 (THR1),
    .THR2 (THR2)
  ) u_quant (
    .sample_i (in_data),
    .code_o   (code)
  );

  assign in_ready = (state_q == FILL);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    beat_acc   = in_valid & in_ready;
    at_last_ch = (ch_cnt_q == LAST_CH);
    good_last  = in_last & at_last_ch;
    bad_frame  = in_last ^ at_last_ch;
    shadow_d   = shadow_q;
    shadow_d[Q_W*int'(ch_cnt_q) +: Q_W] = code;
  end

  // NOTE: the shadow is pure storage and is deliberately left unreset; every slot is rewritten before use.
  always_ff @(posedge clk) begin
    if (beat_acc) shadow_q <= shadow_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      ch_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (beat_acc) begin
            if (good_last) begin
              // shadow_d already carries the last beat's code
              out_data_q  <= shadow_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
              ch_cnt_q    <= '0;
            end else if (bad_frame) begin
              frame_err_q <= 1'b1;
              ch_cnt_q    <= '0;
            end else begin
              ch_cnt_q <= ch_cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;

`ifdef HGCAL_QUANT_SAT_CNT_EN
  logic [15:0] sat_q;

  // Counts full-scale beats even from frames that are later dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= '0;
    end else if (beat_acc && (in_data == {IN_W{1'b1}}) && (sat_q != 16'hFFFF)) begin
      sat_q <= sat_q + 16'd1;
    end
  end

  assign sat_count = sat_q;
`endif

endmodule

// File: tb/tb_hgcal_input_frame_quantizer.sv
// Self-checking bench for hgcal_input_frame_quantizer: directed table, corner
// sequences and randomised frames against a frame-level model.
module tb_hgcal_input_frame_quantizer;
  import hgcal_quant_pkg::*;

  localparam int N_CH  = 48;
  localparam int IN_W  = 10;
  localparam int OUT_W = N_CH * 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [IN_W-1:0]  in_data;
  logic             out_valid, out_ready, frame_err;
  logic [OUT_W-1:0] out_data;
`ifdef HGCAL_QUANT_SAT_CNT_EN
  logic [15:0]      sat_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hgcal_input_frame_quantizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef HGCAL_QUANT_SAT_CNT_EN
    .sat_count (sat_count),
`endif
    .frame_err (frame_err)
  );

  typedef struct {
    logic [IN_W-1:0] sample;
    logic [1:0]      code;
  } qvec_t;

  qvec_t           tbl [8];
  logic [IN_W-1:0] sample_mem [N_CH];
  logic [IN_W-1:0] corner [8];
  logic [OUT_W-1:0] exp_frame;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [OUT_W-1:0] model_frame();
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) r[2*i +: 2] = quant2(32'(sample_mem[i]));
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N_CH; i++) begin
      if ($urandom_range(2, 0) == 0) sample_mem[i] = corner[$urandom_range(7, 0)];
      else                           sample_mem[i] = IN_W'($urandom_range(1023, 0));
    end
  endtask

  // Drives n beats from sample_mem; in_last on index last_at (-1 for none).
  task automatic send_beats(input int n, input int last_at, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int gap;
      int guard;
      gap      = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (gap) tick();
      guard = 0;
      while (!in_ready && guard < 200) begin
        tick();
        guard++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = sample_mem[i];
      in_last  = (i == last_at);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic stable;

    tbl[0] = '{10'd0,    2'd0};
    tbl[1] = '{10'd63,   2'd0};
    tbl[2] = '{10'd64,   2'd1};
    tbl[3] = '{10'd255,  2'd1};
    tbl[4] = '{10'd256,  2'd2};
    tbl[5] = '{10'd511,  2'd2};
    tbl[6] = '{10'd512,  2'd3};
    tbl[7] = '{10'd1023, 2'd3};
    for (int i = 0; i < 8; i++) corner[i] = tbl[i].sample;

    out_ready = 1'b0;
    do_reset();
    check("reset_in_ready",  in_ready,  1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data",  out_data,  0);
    check("reset_frame_err", frame_err, 0);

    // Directed table frame, in_valid held high
    out_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) sample_mem[i] = tbl[i % 8].sample;
    exp_frame = '0;
    for (int i = 0; i < N_CH; i++) exp_frame[2*i +: 2] = tbl[i % 8].code;
    send_beats(N_CH, N_CH - 1, 0);
    check("t1_out_valid", out_valid, 1);
    check("t1_in_ready",  in_ready,  0);
    for (int i = 0; i < N_CH; i++)
      check($sformatf("t1_ch%0d", i), out_data[2*i +: 2], tbl[i % 8].code);
    tick();
    check("t1_valid_one_cycle", out_valid, 0);
    check("t1_in_ready_back",   in_ready,  1);
    check("t1_data_retained",   out_data,  exp_frame);

    // Back-pressure
    out_ready = 1'b0;
    fill_random();
    exp_frame = model_frame();
    send_beats(N_CH, N_CH - 1, 2);
    check("t2_out_valid", out_valid, 1);
    check("t2_out_data",  out_data,  exp_frame);
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_frame) stable = 1'b0;
    end
    check("t2_hold_stable", stable, 1);
    out_ready = 1'b1;
    tick();
    check("t2_released_valid", out_valid, 0);
    check("t2_released_ready", in_ready,  1);

    // Early last on beat 20
    fill_random();
    send_beats(21, 20, 0);
    check("t3_frame_err", frame_err, 1);
    check("t3_no_valid",  out_valid, 0);
    tick();
    check("t3_err_pulse_end", frame_err, 0);
    check("t3_still_no_valid", out_valid, 0);
    fill_random();
    exp_frame = model_frame();
    send_beats(N_CH, N_CH - 1, 1);
    check("t3_next_valid", out_valid, 1);
    check("t3_next_data",  out_data,  exp_frame);
    tick();

    // Missing last
    fill_random();
    send_beats(N_CH, -1, 0);
    check("t4_frame_err", frame_err, 1);
    check("t4_no_valid",  out_valid, 0);
    tick();
    check("t4_err_pulse_end", frame_err, 0);
    fill_random();
    exp_frame = model_frame();
    send_beats(N_CH, N_CH - 1, 0);
    check("t4_restart_valid", out_valid, 1);
    check("t4_restart_data",  out_data,  exp_frame);
    tick();

    // Reset on beat 30 of a frame
    fill_random();
    send_beats(30, -1, 0);
    in_valid = 1'b1;
    in_data  = 10'd1023;
    in_last  = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("t5_out_valid", out_valid, 0);
    check("t5_frame_err", frame_err, 0);
    check("t5_in_ready",  in_ready,  1);
    check("t5_out_data",  out_data,  0);
    fill_random();
    exp_frame = model_frame();
    send_beats(N_CH, N_CH - 1, 0);
    check("t5_fresh_valid", out_valid, 1);
    check("t5_fresh_data",  out_data,  exp_frame);
    tick();

    // Randomised frames with random gaps and hold times
    for (int f = 0; f < 6; f++) begin
      out_ready = 1'b0;
      fill_random();
      exp_frame = model_frame();
      send_beats(N_CH, N_CH - 1, int'($urandom_range(2, 0)));
      check($sformatf("rnd%0d_valid", f), out_valid, 1);
      check($sformatf("rnd%0d_data", f),  out_data,  exp_frame);
      repeat ($urandom_range(4, 0)) tick();
      check($sformatf("rnd%0d_hold", f), out_data, exp_frame);
      out_ready = 1'b1;
      tick();
      check($sformatf("rnd%0d_done", f), out_valid, 0);
    end

`ifdef HGCAL_QUANT_SAT_CNT_EN
    do_reset();
    check("t6_sat_reset", sat_count, 0);
    for (int i = 0; i < N_CH; i++)
      sample_mem[i] = (i < 5) ? 10'd1023 : IN_W'($urandom_range(1022, 0));
    send_beats(N_CH, N_CH - 1, 0);
    check("t6_sat_five", sat_count, 5);
    tick();
    for (int i = 0; i < N_CH; i++) sample_mem[i] = 10'd1023;
    for (int k = 0; k < 1365; k++) send_beats(N_CH, -1, 0);
    check("t6_sat_near_max", sat_count, 16'd65525);
    send_beats(N_CH, -1, 0);
    check("t6_sat_saturated", sat_count, 16'hFFFF);
    send_beats(N_CH, -1, 0);
    check("t6_sat_held", sat_count, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
